// File: rtl/px_router_pkg.sv
// Shared types for the pixel-stream router.
//   mode_t  : routing mode requested / applied
//   state_t : router FSM state
//   feeds_core() : true for modes whose source goes into the core
package px_router_pkg;
  localparam int MAX_PIXEL_BITS = 24;

  typedef enum logic [1:0] {
    SPI_CORE  = 2'd0,
    LFSR_CORE = 2'd1,
    LFSR_CFG  = 2'd2,
    LOOPBACK  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic feeds_core(mode_t m);
    return (m == SPI_CORE) || (m == LFSR_CORE);
  endfunction
endpackage

// File: rtl/px_stream_router_if.sv
// Pixel-stream bundle between the tile environment (master) and the router (slave).
// *_i are driven by the environment, *_o by the router.
interface px_stream_router_if #(parameter int PX_W = px_router_pkg::MAX_PIXEL_BITS);
  logic [1:0]      mode_i;
  logic [PX_W-1:0] spi_px_i;
  logic            spi_rdy_i;
  logic            spi_free_i;
  logic [PX_W-1:0] spi_px_o;
  logic            spi_rdy_o;
  logic [PX_W-1:0] core_px_o;
  logic            core_rdy_o;
  logic [PX_W-1:0] core_px_i;
  logic            core_rdy_i;
  logic [PX_W-1:0] lfsr_cfg_px_o;
  logic            lfsr_cfg_rdy_o;
  logic [PX_W-1:0] lfsr_cfg_px_i;
  logic            lfsr_cfg_done_i;
  logic [PX_W-1:0] lfsr_px_i;
  logic            lfsr_rdy_i;
  logic [1:0]      mode_o;
  logic            busy_o;
  logic            ovf_o;
  logic            drop_o;
  logic            timeout_o;

  modport slave (
    input  mode_i, spi_px_i, spi_rdy_i, spi_free_i, core_px_i, core_rdy_i,
           lfsr_cfg_px_i, lfsr_cfg_done_i, lfsr_px_i, lfsr_rdy_i,
    output spi_px_o, spi_rdy_o, core_px_o, core_rdy_o, lfsr_cfg_px_o,
           lfsr_cfg_rdy_o, mode_o, busy_o, ovf_o, drop_o, timeout_o
  );

  modport master (
    output mode_i, spi_px_i, spi_rdy_i, spi_free_i, core_px_i, core_rdy_i,
           lfsr_cfg_px_i, lfsr_cfg_done_i, lfsr_px_i, lfsr_rdy_i,
    input  spi_px_o, spi_rdy_o, core_px_o, core_rdy_o, lfsr_cfg_px_o,
           lfsr_cfg_rdy_o, mode_o, busy_o, ovf_o, drop_o, timeout_o
  );
endinterface

// File: rtl/px_sync_fifo.sv
// Synchronous result FIFO, DEPTH a power of 2.
//   i_push/i_data : write; ignored when full unless popping in the same cycle
//   i_pop         : read head (o_data is the head, valid while !o_empty)
//   i_flush       : discard all entries (wins over push/pop)
//   o_full/o_empty/o_count : occupancy
module px_sync_fifo #(
  parameter int PX_W  = 24,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            nreset_i,
  input  logic            i_flush,
  input  logic            i_push,
  input  logic [PX_W-1:0] i_data,
  input  logic            i_pop,
  output logic [PX_W-1:0] o_data,
  output logic            o_full,
  output logic            o_empty,
  output logic [AW:0]     o_count
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [PX_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_cnt;
  logic            w_wr, w_rd;

  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_data  = r_mem[r_rptr];
  assign w_rd    = i_pop && !o_empty;
  // a pop frees the slot in the same cycle, so a full FIFO still takes the write
  assign w_wr    = i_push && (!o_full || w_rd);

  always_ff @(posedge clk_i) begin
    if (w_wr && !i_flush) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      // pointers wrap naturally: DEPTH is a power of 2
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/px_stream_router.sv
// Pixel-stream crossbar between the SPI block, the LFSR and the gray/sobel core.
//   clk_i, nreset_i : clock, async active-low reset
//   bus (slave)     : all stream, status and mode signals (see px_stream_router_if)
// Mode changes drain in-flight pixels and buffered results before the new mode
// is applied; a silent core forces the swap after DRAIN_TO idle cycles.
module px_stream_router
  import px_router_pkg::*;
#(
  parameter int PX_W       = MAX_PIXEL_BITS,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_INFL   = 7,
  parameter int DRAIN_TO   = 255
) (
  input logic               clk_i,
  input logic               nreset_i,
  px_stream_router_if.slave bus
);
  localparam int IW  = $clog2(MAX_INFL + 1);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam logic [IW-1:0] INFL_MAX = IW'(MAX_INFL);
  localparam logic [7:0]    TO_LAST  = 8'(DRAIN_TO - 1);

  state_t          r_state;
  mode_t           r_mode;
  logic [IW-1:0]   r_infl;
  logic [7:0]      r_to_cnt;
  logic            r_spi_rdy, r_core_rdy, r_cfg_rdy, r_busy, r_ovf, r_drop, r_to;
  logic [PX_W-1:0] r_spi_px, r_core_px, r_cfg_px;

  mode_t           w_req;
  logic            w_core_mode, w_run, w_active, w_src_stb, w_res_stb, w_lb;
  logic            w_push, w_pop, w_issue, w_infl_full, w_infl_inc, w_infl_dec;
  logic            w_drop_now, w_drained, w_timeout, w_ovf;
  logic            w_fifo_full, w_fifo_empty;
  logic [FAW:0]    w_fifo_cnt;
  logic [PX_W-1:0] w_src_px, w_res_px, w_push_px, w_fifo_px;

  assign w_req       = mode_t'(bus.mode_i);
  assign w_core_mode = feeds_core(r_mode);
  assign w_run       = (r_state == RUN);
  assign w_active    = (r_state != IDLE);

  // source of the applied mode; in LFSR_CORE the SPI strobe is ignored
  assign w_src_stb = (r_mode == LFSR_CORE) ? bus.lfsr_rdy_i : bus.spi_rdy_i;
  assign w_src_px  = (r_mode == LFSR_CORE) ? bus.lfsr_px_i  : bus.spi_px_i;

  // results are accepted in RUN and DRAIN; loopback is a source, so RUN only
  assign w_res_stb = w_active & (w_core_mode ? bus.core_rdy_i
                                             : ((r_mode == LFSR_CFG) & bus.lfsr_cfg_done_i));
  assign w_res_px  = w_core_mode ? bus.core_px_i : bus.lfsr_cfg_px_i;
  assign w_lb      = w_run & (r_mode == LOOPBACK) & bus.spi_rdy_i;
  assign w_push    = w_res_stb | w_lb;
  assign w_push_px = w_lb ? bus.spi_px_i : w_res_px;

  assign w_infl_full = (r_infl == INFL_MAX);
  assign w_issue     = w_run & w_src_stb & (r_mode != LOOPBACK) & ~(w_core_mode & w_infl_full);
  assign w_infl_inc  = w_issue & w_core_mode;
  assign w_infl_dec  = w_core_mode & w_res_stb & (r_infl != '0);
  assign w_drop_now  = w_src_stb & ((r_state == DRAIN) | (w_run & w_core_mode & w_infl_full));

  assign w_drained = (r_infl == '0) & w_fifo_empty;
  assign w_timeout = (r_state == DRAIN) & ~w_drained & ~w_res_stb & (r_to_cnt == TO_LAST);

  // one idle cycle is enforced between pulses by looking at the last pulse
  assign w_pop = ~w_fifo_empty & bus.spi_free_i & ~r_spi_rdy & ~w_timeout;
  assign w_ovf = w_push & w_fifo_full & ~w_pop & ~w_timeout;

  px_sync_fifo #(.PX_W(PX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .i_flush  (w_timeout),
    .i_push   (w_push),
    .i_data   (w_push_px),
    .i_pop    (w_pop),
    .o_data   (w_fifo_px),
    .o_full   (w_fifo_full),
    .o_empty  (w_fifo_empty),
    .o_count  (w_fifo_cnt)
  );

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_state    <= IDLE;
      r_mode     <= SPI_CORE;
      r_infl     <= '0;
      r_to_cnt   <= '0;
      r_spi_rdy  <= 1'b0;
      r_core_rdy <= 1'b0;
      r_cfg_rdy  <= 1'b0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
      r_drop     <= 1'b0;
      r_to       <= 1'b0;
      r_spi_px   <= '0;
      r_core_px  <= '0;
      r_cfg_px   <= '0;
    end else begin
      r_spi_rdy <= w_pop;
      if (w_pop) r_spi_px <= w_fifo_px;
      r_core_rdy <= w_infl_inc;
      if (w_infl_inc) r_core_px <= w_src_px;
      r_cfg_rdy <= w_issue & (r_mode == LFSR_CFG);
      if (w_issue & (r_mode == LFSR_CFG)) r_cfg_px <= bus.spi_px_i;
      // registered so it reads 0 out of reset; trails the state by one cycle
      r_busy <= (r_state != RUN) | (r_infl != '0) | (w_fifo_cnt != '0);

      if (w_infl_inc & ~w_infl_dec)      r_infl <= r_infl + IW'(1);
      else if (~w_infl_inc & w_infl_dec) r_infl <= r_infl - IW'(1);

      if (w_ovf)      r_ovf  <= 1'b1;
      if (w_drop_now) r_drop <= 1'b1;

      case (r_state)
        IDLE: begin
          r_mode  <= w_req;
          r_state <= RUN;
          r_ovf   <= 1'b0;
          r_drop  <= 1'b0;
          r_to    <= 1'b0;
        end
        RUN: begin
          r_to_cnt <= '0;
          if (w_req != r_mode) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_drained) r_state <= IDLE;
          else if (w_timeout) begin
            r_to    <= 1'b1;
            r_infl  <= '0;
            r_state <= IDLE;
          end
          else if (w_res_stb) r_to_cnt <= '0;
          else                r_to_cnt <= r_to_cnt + 8'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.spi_px_o       = r_spi_px;
  assign bus.spi_rdy_o      = r_spi_rdy;
  assign bus.core_px_o      = r_core_px;
  assign bus.core_rdy_o     = r_core_rdy;
  assign bus.lfsr_cfg_px_o  = r_cfg_px;
  assign bus.lfsr_cfg_rdy_o = r_cfg_rdy;
  assign bus.mode_o         = r_mode;
  assign bus.busy_o         = r_busy;
  assign bus.ovf_o          = r_ovf;
  assign bus.drop_o         = r_drop;
  assign bus.timeout_o      = r_to;
endmodule

// File: tb/tb_px_stream_router.sv
module tb_px_stream_router;
  localparam int PX_W = 24, DEPTH = 4, MAXI = 7, DTO = 255;
  typedef logic [PX_W-1:0] px_t;

  logic clk = 1'b0, nrst = 1'b0;
  always #5 clk = ~clk;

  px_stream_router_if #(.PX_W(PX_W)) bus ();
  px_stream_router #(.PX_W(PX_W), .FIFO_DEPTH(DEPTH), .MAX_INFL(MAXI), .DRAIN_TO(DTO)) dut (
    .clk_i(clk), .nreset_i(nrst), .bus(bus));

  int n_vec = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({|bus.spi_px_o, bus.spi_rdy_o, |bus.core_px_o, bus.core_rdy_o,
                |bus.lfsr_cfg_px_o, bus.lfsr_cfg_rdy_o, bus.mode_o, bus.busy_o,
                bus.ovf_o, bus.drop_o, bus.timeout_o});
  endfunction

  // ---- core model: returns px+1 five cycles after each core strobe ----
  bit  core_en = 1'b1;
  px_t core_qp[$];
  int  core_qt[$];
  initial begin
    bus.core_rdy_i = 1'b0; bus.core_px_i = '0;
    forever begin
      @(negedge clk);
      bus.core_rdy_i = 1'b0;
      if (!nrst) begin core_qp.delete(); core_qt.delete(); end
      else begin
        if (bus.core_rdy_o && core_en) begin
          core_qp.push_back(px_t'(bus.core_px_o + px_t'(1)));
          core_qt.push_back(cyc + 5);
        end
        if (core_qt.size() > 0 && core_qt[0] <= cyc) begin
          bus.core_rdy_i = 1'b1;
          bus.core_px_i  = core_qp.pop_front();
          void'(core_qt.pop_front());
        end
      end
    end
  end

  // ---- LFSR config model: readback = word ^ A5A5A5 three cycles later ----
  px_t cfg_qp[$];
  int  cfg_qt[$];
  initial begin
    bus.lfsr_cfg_done_i = 1'b0; bus.lfsr_cfg_px_i = '0;
    forever begin
      @(negedge clk);
      bus.lfsr_cfg_done_i = 1'b0;
      if (!nrst) begin cfg_qp.delete(); cfg_qt.delete(); end
      else begin
        if (bus.lfsr_cfg_rdy_o) begin
          cfg_qp.push_back(bus.lfsr_cfg_px_o ^ 24'hA5A5A5);
          cfg_qt.push_back(cyc + 3);
        end
        if (cfg_qt.size() > 0 && cfg_qt[0] <= cyc) begin
          bus.lfsr_cfg_done_i = 1'b1;
          bus.lfsr_cfg_px_i   = cfg_qp.pop_front();
          void'(cfg_qt.pop_front());
        end
      end
    end
  end

  // ---- output scoreboard: every spi_rdy_o pulse must match the next expected word ----
  px_t exp_q[$];
  px_t core_seen[$];
  int  n_pulse = 0;
  bit  prev_rdy = 1'b0;
  initial forever begin
    @(negedge clk);
    if (bus.spi_rdy_o) begin
      n_pulse++;
      chk("pulse_gap", 32'(prev_rdy), 32'd0);
      if (exp_q.size() == 0) chk("extra_pulse", 32'd1, 32'd0);
      else chk("spi_px_o", 32'(bus.spi_px_o), 32'(exp_q.pop_front()));
    end
    if (bus.core_rdy_o) core_seen.push_back(bus.core_px_o);
    prev_rdy = bus.spi_rdy_o;
  end

  task automatic spi_stb(px_t px);
    bus.spi_px_i = px; bus.spi_rdy_i = 1'b1;
    @(negedge clk);
    bus.spi_rdy_i = 1'b0;
  endtask

  task automatic wait_mode(logic [1:0] m, string tag);
    int k = 0;
    while (bus.mode_o !== m && k < 400) begin @(negedge clk); k++; end
    chk(tag, 32'(bus.mode_o), 32'(m));
  endtask

  task automatic wait_done(string tag);
    int k = 0;
    while ((exp_q.size() != 0 || bus.busy_o !== 1'b0) && k < 400) begin @(negedge clk); k++; end
    chk(tag, 32'(exp_q.size() == 0 && bus.busy_o === 1'b0), 32'd1);
  endtask

  initial begin
    int p0;
    px_t v, lv[$];
    int ref_n;
    bus.mode_i = 2'd0; bus.spi_px_i = '0; bus.spi_rdy_i = 1'b0; bus.spi_free_i = 1'b1;
    bus.lfsr_px_i = '0; bus.lfsr_rdy_i = 1'b0;
    #1 chk("reset_outs", outs(), 32'd0);
    repeat (2) @(negedge clk);
    chk("reset_outs_held", outs(), 32'd0);
    nrst = 1'b1;
    repeat (4) @(negedge clk);
    chk("run_mode0", 32'(bus.mode_o), 32'd0);
    chk("run_idle", 32'(bus.busy_o), 32'd0);

    // 1: SPI_CORE round trip
    p0 = n_pulse;
    foreach (lv[i]) ; // keep lv empty
    spi_stb(24'h111111); exp_q.push_back(24'h111112); @(negedge clk);
    spi_stb(24'h222222); exp_q.push_back(24'h222223); @(negedge clk);
    spi_stb(24'h333333); exp_q.push_back(24'h333334);
    wait_done("t1_done");
    chk("t1_pulses", 32'(n_pulse - p0), 32'd3);

    // 2: LOOPBACK with SPI blocked -> overflow, then drain in order
    bus.mode_i = 2'd3;
    wait_mode(2'd3, "t2_mode");
    bus.spi_free_i = 1'b0;
    ref_n = 0;
    for (int i = 0; i < 5; i++) begin
      v = px_t'($urandom);
      if (ref_n < DEPTH) begin exp_q.push_back(v); ref_n++; end
      spi_stb(v);
    end
    repeat (2) @(negedge clk);
    chk("t2_ovf", 32'(bus.ovf_o), 32'd1);
    chk("t2_busy", 32'(bus.busy_o), 32'd1);
    chk("t2_no_pulse", 32'(bus.spi_rdy_o), 32'd0);
    p0 = n_pulse;
    bus.spi_free_i = 1'b1;
    wait_done("t2_done");
    chk("t2_pulses", 32'(n_pulse - p0), 32'd4);

    // 3: mode 0 -> 2 with two pixels in flight
    bus.mode_i = 2'd0;
    wait_mode(2'd0, "t3_mode0");
    @(negedge clk);
    chk("t3_ovf_cleared", 32'(bus.ovf_o), 32'd0);
    p0 = n_pulse;
    v = px_t'($urandom); exp_q.push_back(px_t'(v + px_t'(1))); spi_stb(v); @(negedge clk);
    v = px_t'($urandom); exp_q.push_back(px_t'(v + px_t'(1))); spi_stb(v);
    bus.mode_i = 2'd2;
    repeat (2) @(negedge clk);
    chk("t3_mode_held", 32'(bus.mode_o), 32'd0);
    spi_stb(24'h0BAD00);
    chk("t3_drop", 32'(bus.drop_o), 32'd1);
    wait_mode(2'd2, "t3_mode2");
    chk("t3_popped_first", 32'(n_pulse - p0), 32'd2);

    // LFSR_CFG: SPI words go to LFSR config, readback returns through FIFO
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      v = px_t'($urandom); exp_q.push_back(v ^ 24'hA5A5A5); spi_stb(v); @(negedge clk);
    end
    wait_done("cfg_done");

    // 5: LFSR_CORE with a silent core saturates the in-flight count
    core_en = 1'b0;
    bus.mode_i = 2'd1;
    wait_mode(2'd1, "t5_mode");
    core_seen.delete(); lv.delete();
    for (int i = 0; i < 8; i++) begin
      v = px_t'($urandom); lv.push_back(v);
      bus.lfsr_px_i = v; bus.lfsr_rdy_i = 1'b1;
      @(negedge clk);
    end
    bus.lfsr_rdy_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_core_cnt", 32'(core_seen.size()), 32'd7);
    chk("t5_drop", 32'(bus.drop_o), 32'd1);
    for (int i = 0; i < 7 && i < core_seen.size(); i++)
      chk("t5_core_px", 32'(core_seen[i]), 32'(lv[i]));

    // 4: drain with silent core times out after DRAIN_TO idle cycles
    bus.mode_i = 2'd0;
    repeat (DTO) @(negedge clk);
    chk("t4_no_to_yet", 32'(bus.timeout_o), 32'd0);
    @(negedge clk);
    chk("t4_timeout", 32'(bus.timeout_o), 32'd1);
    chk("t4_mode_old", 32'(bus.mode_o), 32'd1);
    @(negedge clk);
    chk("t4_mode_new", 32'(bus.mode_o), 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_idle", 32'(bus.busy_o), 32'd0);
    chk("t4_drop_cleared", 32'(bus.drop_o), 32'd0);
    core_en = 1'b1;

    // randomized SPI_CORE traffic
    p0 = n_pulse;
    for (int i = 0; i < 30; i++) begin
      v = px_t'($urandom); exp_q.push_back(px_t'(v + px_t'(1))); spi_stb(v);
      repeat ($urandom_range(2, 4)) @(negedge clk);
    end
    wait_done("rnd_done");
    chk("rnd_pulses", 32'(n_pulse - p0), 32'd30);
    chk("rnd_ovf", 32'(bus.ovf_o), 32'd0);
    chk("rnd_drop", 32'(bus.drop_o), 32'd0);

    // 6: async reset mid-stream
    for (int i = 0; i < 3; i++) begin spi_stb(px_t'($urandom)); @(negedge clk); end
    #2 nrst = 1'b0;
    #1 chk("t6_reset_outs", outs(), 32'd0);
    exp_q.delete();
    bus.mode_i = 2'd3;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("t6_mode", 32'(bus.mode_o), 32'd3);
    repeat (3) @(negedge clk);
    chk("t6_idle", 32'(bus.busy_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
